hwpe_stream_split_buffered: RTL and testbench

HWPE_STREAM_SPLIT_BUFFERED -- requirements
Module: hwpe_stream_split_buffered

---
 rtl/hwpe_stream_split_buffered_if.sv | 15 +
 rtl/hwpe_stream_split_buffered.sv | 109 ++++++++++
 tb/tb_hwpe_stream_split_buffered.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hwpe_stream_split_buffered_if.sv
// Valid/ready stream bundle carrying data plus byte strobes.
// The sink modport receives a stream and the source modport drives one.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/hwpe_stream_split_buffered.sv
// Splits one wide stream into NB_OUT_STREAMS slices, each with its own FIFO so consumers may skew.
// Define HWPE_STREAM_SPLIT_BUFFERED_STATS_EN to add the stall_cnt_o input-stall counter.
module hwpe_stream_split_buffered #(
  parameter int unsigned NB_OUT_STREAMS = 2,
  parameter int unsigned DATA_WIDTH_IN  = 128,
  parameter int unsigned FIFO_DEPTH     = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
`ifdef HWPE_STREAM_SPLIT_BUFFERED_STATS_EN
  output logic [31:0]            stall_cnt_o,
`endif
  hwpe_stream_intf_stream.sink   push_i,
  hwpe_stream_intf_stream.source pop_o [NB_OUT_STREAMS-1:0]
);

  localparam int unsigned W  = DATA_WIDTH_IN / NB_OUT_STREAMS;
  localparam int unsigned SW = W / 8;
  localparam int unsigned EW = W + SW;
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [NB_OUT_STREAMS-1:0] full;
  logic                      ready_en_q;
  logic                      push_ready;
  logic                      push_hs;

  // Ready stays low for the cycle in which reset is released.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
    end
  end

  assign push_ready   = ready_en_q & ~(|full) & ~clear_i;
  assign push_i.ready = push_ready;
  assign push_hs      = push_i.valid & push_ready;

  for (genvar i = 0; i < NB_OUT_STREAMS; i++) begin : g_fifo
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic [EW-1:0] rd_entry;
    logic          empty;
    logic          pop_hs;

    assign empty    = (cnt_q == '0);
    assign full[i]  = (cnt_q == CW'(FIFO_DEPTH));
    assign pop_hs   = ~empty & pop_o[i].ready;
    assign rd_entry = mem_q[rd_ptr_q];

    assign pop_o[i].valid = ~empty;
    assign pop_o[i].data  = empty ? '0 : rd_entry[EW-1:SW];
    assign pop_o[i].strb  = empty ? '0 : rd_entry[SW-1:0];

    // push_hs is already blocked by clear_i, so only the pop side needs the guard.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else if (clear_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (push_hs) begin
          wr_ptr_q <= wr_ptr_q + AW'(1);
        end
        if (pop_hs) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
        end
        if (push_hs && !pop_hs) begin
          cnt_q <= cnt_q + CW'(1);
        end else if (!push_hs && pop_hs) begin
          cnt_q <= cnt_q - CW'(1);
        end
      end
    end

    // Storage needs no reset: the read side is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
      if (push_hs) begin
        mem_q[wr_ptr_q] <= {push_i.data[i*W +: W], push_i.strb[i*SW +: SW]};
      end
    end
  end

`ifdef HWPE_STREAM_SPLIT_BUFFERED_STATS_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (clear_i) begin
      stall_cnt_q <= '0;
    end else if (push_i.valid && !push_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hwpe_stream_split_buffered.sv
// Scoreboard bench for hwpe_stream_split_buffered: accepted words are kept whole in a queue and
// each output keeps its own read index into it; a negedge monitor compares every output.
module tb_hwpe_stream_split_buffered;
  localparam int unsigned NB    = 2;
  localparam int unsigned DW    = 128;
  localparam int unsigned W     = 64;
  localparam int unsigned SW    = 8;
  localparam int unsigned DEPTH = 2;

  logic clk    = 1'b0;
  logic rst_ni = 1'b0;
  logic clear  = 1'b0;
  always #5 clk = ~clk;

  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) push ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(W))  pop [NB-1:0] ();

  logic [NB-1:0] pr;
  logic [NB-1:0] pv;
  logic [W-1:0]  pd [NB];
  logic [SW-1:0] ps [NB];
`ifdef HWPE_STREAM_SPLIT_BUFFERED_STATS_EN
  logic [31:0]   stall_cnt;
`endif

  for (genvar g = 0; g < NB; g++) begin : g_pop
    assign pv[g]        = pop[g].valid;
    assign pd[g]        = pop[g].data;
    assign ps[g]        = pop[g].strb;
    assign pop[g].ready = pr[g];
  end

  hwpe_stream_split_buffered #(
    .NB_OUT_STREAMS(NB),
    .DATA_WIDTH_IN (DW),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .clear_i    (clear),
`ifdef HWPE_STREAM_SPLIT_BUFFERED_STATS_EN
    .stall_cnt_o(stall_cnt),
`endif
    .push_i     (push),
    .pop_o      (pop)
  );

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference model: every accepted word, plus how far each consumer has read.
  logic [127:0] wdata [$];
  logic [15:0]  wstrb [$];
  int           rd_idx   [NB];
  int unsigned  obs_pops [NB];
  int unsigned  acc_cnt = 0;
  logic         done_rst;
  logic         exp_rdy;
  logic [127:0] md;
  logic [15:0]  ms;

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) done_rst <= 1'b0;
    else         done_rst <= 1'b1;
  end

  initial begin
    for (int i = 0; i < NB; i++) begin
      rd_idx[i]   = 0;
      obs_pops[i] = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst_ni) begin
      check("ready_in_reset", push.ready, 1'b0);
      for (int i = 0; i < NB; i++) begin
        check("valid_in_reset", pv[i], 1'b0);
        check("data_in_reset", pd[i], '0);
        check("strb_in_reset", ps[i], '0);
        rd_idx[i] = wdata.size();
      end
    end else begin
      exp_rdy = done_rst && !clear;
      for (int i = 0; i < NB; i++) begin
        if (wdata.size() - rd_idx[i] >= DEPTH) exp_rdy = 1'b0;
      end
      check("push_ready", push.ready, exp_rdy);
      if (push.valid && push.ready) acc_cnt++;
      for (int i = 0; i < NB; i++) begin
        if (pv[i] && pr[i]) obs_pops[i]++;
        if (rd_idx[i] < wdata.size()) begin
          md = wdata[rd_idx[i]];
          ms = wstrb[rd_idx[i]];
          check("pop_valid", pv[i], 1'b1);
          check("pop_data", pd[i], md[i*W +: W]);
          check("pop_strb", ps[i], ms[i*SW +: SW]);
          if (pr[i] && !clear) rd_idx[i]++;
        end else begin
          check("pop_valid_idle", pv[i], 1'b0);
          check("pop_data_idle", pd[i], '0);
          check("pop_strb_idle", ps[i], '0);
        end
      end
      if (clear) begin
        for (int i = 0; i < NB; i++) rd_idx[i] = wdata.size();
      end else if (push.valid && exp_rdy) begin
        wdata.push_back(push.data);
        wstrb.push_back(push.strb);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rand();
    push.valid = 1'b1;
    push.data  = {$urandom, $urandom, $urandom, $urandom};
    push.strb  = 16'($urandom);
  endtask

  int unsigned base;

  initial begin
    push.valid = 1'b0;
    push.data  = '0;
    push.strb  = '0;
    pr         = '1;
    repeat (2) tick();
    rst_ni = 1'b1;
    tick();
    check("ready_after_reset", push.ready, 1'b1);

    // Basic split at full throughput.
    push.valid = 1'b1;
    push.data  = {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555};
    push.strb  = '1;
    tick();
    push.data  = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
    push.strb  = 16'h0FF0;
    check("split_lo", pd[0], 64'h5555_5555_5555_5555);
    check("split_hi", pd[1], 64'hAAAA_AAAA_AAAA_AAAA);
    check("split_ready", push.ready, 1'b1);
    tick();
    push.valid = 1'b0;
    check("split2_lo", pd[0], 64'hFEDC_BA98_7654_3210);
    check("split2_hi", pd[1], 64'h0123_4567_89AB_CDEF);
    check("split2_strb_lo", ps[0], 8'hF0);
    check("split2_strb_hi", ps[1], 8'h0F);
    tick();
    check("split_drained", pv, 2'b00);

    // Skew: slow consumer 1 backs up the input after two words.
    pr   = 2'b01;
    base = obs_pops[0];
    push_rand();
    tick();
    push_rand();
    tick();
    push_rand();
    check("skew_ready_low", push.ready, 1'b0);
    repeat (3) tick();
    check("skew_ready_held", push.ready, 1'b0);
    check("skew_fast_pops", obs_pops[0] - base, 2);
    pr   = 2'b11;
    base = acc_cnt;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (acc_cnt != base) break;
    end
    check("skew_third_accepted", acc_cnt - base, 1);
    push.valid = 1'b0;
    repeat (4) tick();
    check("skew_drained", pv, 2'b00);

    // Full FIFOs: ready stays low in the cycle the consumers pop.
    pr = 2'b00;
    push_rand();
    tick();
    push_rand();
    tick();
    push_rand();
    pr = 2'b11;
    check("full_ready_low", push.ready, 1'b0);
    tick();
    check("full_ready_back", push.ready, 1'b1);
    tick();
    push.valid = 1'b0;
    repeat (4) tick();

    // Clear with two words buffered and a push pending.
    pr = 2'b00;
    push_rand();
    tick();
    push_rand();
    tick();
    push_rand();
    clear = 1'b1;
    tick();
    clear      = 1'b0;
    push.valid = 1'b0;
    check("clear_empties", pv, 2'b00);
    pr = 2'b11;
    tick();
    check("clear_word_lost", pv, 2'b00);

    // Asynchronous reset between clock edges.
    pr = 2'b00;
    push_rand();
    tick();
    check("pre_reset_valid", pv, 2'b11);
    #2;
    rst_ni = 1'b0;
    #1;
    push.valid = 1'b0;
    check("async_reset_valid", pv, 2'b00);
    check("async_reset_ready", push.ready, 1'b0);
    @(posedge clk);
    #3;
    rst_ni = 1'b1;
    tick();
    check("ready_after_release", push.ready, 1'b1);
    check("reset_no_survivor", pv, 2'b00);

`ifdef HWPE_STREAM_SPLIT_BUFFERED_STATS_EN
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("stall_zero", stall_cnt, 32'd0);
    pr = 2'b00;
    push_rand();
    tick();
    push_rand();
    tick();
    push_rand();
    repeat (5) tick();
    push.valid = 1'b0;
    check("stall_five", stall_cnt, 32'd5);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("stall_cleared", stall_cnt, 32'd0);
`endif

    // Randomised traffic with skewed consumers and occasional flushes.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) != 0) push_rand();
      else begin
        push.valid = 1'b0;
        push.data  = {$urandom, $urandom, $urandom, $urandom};
      end
      pr[0] = ($urandom_range(0, 4) != 0);
      pr[1] = (c % 400 < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 63) == 0);
      tick();
    end
    push.valid = 1'b0;
    clear      = 1'b0;
    pr         = 2'b11;
    repeat (6) tick();
    check("final_drain", pv, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
